// File: rtl/sw_scan_ctrl.sv
// Sliding-window scan controller: tracks the cell position in a COL_N x ROW_N
// frame and reports each window whose bottom-right corner is the current cell.
module sw_scan_ctrl #(
    parameter int unsigned COL_N    = 39,
    parameter int unsigned ROW_N    = 29,
    parameter int unsigned WIN_C    = 7,
    parameter int unsigned WIN_R    = 15,
    parameter int unsigned STRIDE_C = 1,
    parameter int unsigned STRIDE_R = 1,
    parameter int unsigned CW       = 6,
    parameter int unsigned RW       = 5,
    parameter int unsigned IW       = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    input  logic          i_sync,
    output logic          o_valid,
    output logic [CW-1:0] o_col,
    output logic [RW-1:0] o_row,
    output logic [IW-1:0] o_idx,
    output logic          o_sof,
    output logic          o_eof
);

    localparam int unsigned PCW = (STRIDE_C > 1) ? $clog2(STRIDE_C) : 1;
    localparam int unsigned PRW = (STRIDE_R > 1) ? $clog2(STRIDE_R) : 1;

    localparam logic [CW-1:0]  COL_LAST = CW'(COL_N - 1);
    localparam logic [RW-1:0]  ROW_LAST = RW'(ROW_N - 1);
    localparam logic [CW-1:0]  WC_LAST  = CW'(WIN_C - 1);
    localparam logic [RW-1:0]  WR_LAST  = RW'(WIN_R - 1);
    localparam logic [PCW-1:0] PC_LAST  = PCW'(STRIDE_C - 1);
    localparam logic [PRW-1:0] PR_LAST  = PRW'(STRIDE_R - 1);

    logic [CW-1:0]  col_q, col_d, cur_col, ocol_q, ocol_d;
    logic [RW-1:0]  row_q, row_d, cur_row, orow_q, orow_d;
    logic [PCW-1:0] phc_q, phc_d, cur_phc;
    logic [PRW-1:0] phr_q, phr_d, cur_phr;
    logic [IW-1:0]  idx_q, idx_d, cur_idx, oidx_q, oidx_d;
    logic           valid_q, valid_d, sof_q, sof_d, eof_q, eof_d;
    logic           col_ok, row_ok, col_at_last, row_at_last;

    // Position bookkeeping and window-completion decode for the incoming cell
    always_comb begin
        cur_col     = i_sync ? '0 : col_q;
        cur_row     = i_sync ? '0 : row_q;
        cur_phc     = i_sync ? '0 : phc_q;
        cur_phr     = i_sync ? '0 : phr_q;
        cur_idx     = i_sync ? '0 : idx_q;
        col_d       = cur_col;
        row_d       = cur_row;
        phc_d       = cur_phc;
        phr_d       = cur_phr;
        idx_d       = cur_idx;
        ocol_d      = ocol_q;
        orow_d      = orow_q;
        oidx_d      = oidx_q;
        valid_d     = 1'b0;
        sof_d       = 1'b0;
        eof_d       = 1'b0;
        col_at_last = (cur_col == COL_LAST);
        row_at_last = (cur_row == ROW_LAST);
        col_ok      = (cur_col >= WC_LAST) && (cur_phc == '0);
        row_ok      = (cur_row >= WR_LAST) && (cur_phr == '0);

        if (i_valid) begin
            sof_d = (cur_col == '0) && (cur_row == '0);
            eof_d = col_at_last && row_at_last;
            if (col_ok && row_ok) begin
                valid_d = 1'b1;
                ocol_d  = CW'(cur_col - WC_LAST);
                orow_d  = RW'(cur_row - WR_LAST);
                oidx_d  = cur_idx;
                idx_d   = IW'(cur_idx + IW'(1));
            end
            if (eof_d) begin
                idx_d = '0;
            end
            // Phases start at the first column/row that can close a window
            if (col_at_last) begin
                col_d = '0;
                phc_d = '0;
                if (row_at_last) begin
                    row_d = '0;
                    phr_d = '0;
                end else begin
                    row_d = RW'(cur_row + RW'(1));
                    if (cur_row >= WR_LAST) begin
                        phr_d = (cur_phr == PR_LAST) ? '0 : PRW'(cur_phr + PRW'(1));
                    end else begin
                        phr_d = '0;
                    end
                end
            end else begin
                col_d = CW'(cur_col + CW'(1));
                if (cur_col >= WC_LAST) begin
                    phc_d = (cur_phc == PC_LAST) ? '0 : PCW'(cur_phc + PCW'(1));
                end else begin
                    phc_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            phc_q   <= '0;
            phr_q   <= '0;
            idx_q   <= '0;
            ocol_q  <= '0;
            orow_q  <= '0;
            oidx_q  <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            phc_q   <= phc_d;
            phr_q   <= phr_d;
            idx_q   <= idx_d;
            ocol_q  <= ocol_d;
            orow_q  <= orow_d;
            oidx_q  <= oidx_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
        end
    end

    assign o_valid = valid_q;
    assign o_col   = ocol_q;
    assign o_row   = orow_q;
    assign o_idx   = oidx_q;
    assign o_sof   = sof_q;
    assign o_eof   = eof_q;

endmodule

// File: tb/tb_sw_scan_ctrl.sv
// Bench for sw_scan_ctrl: default-geometry instance checked cycle by cycle
// against a behavioural model, plus a small strided instance.
module tb_sw_scan_ctrl;

    localparam int CN = 39;
    localparam int RN = 29;
    localparam int WC = 7;
    localparam int WR = 15;
    localparam int FRAME = CN * RN;

    typedef struct packed {
        logic        v;
        logic        sof;
        logic        eof;
        logic [5:0]  col;
        logic [4:0]  row;
        logic [10:0] idx;
    } obs_t;

    typedef struct packed {
        logic [5:0]  col;
        logic [4:0]  row;
        logic [10:0] idx;
    } win_t;

    logic        clk, rst;
    logic        i_valid, i_sync, s_valid, s_sync;
    logic        o_valid, o_sof, o_eof, so_valid, so_sof, so_eof;
    logic [5:0]  o_col, so_col;
    logic [4:0]  o_row, so_row;
    logic [10:0] o_idx, so_idx;

    sw_scan_ctrl u_dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_sync(i_sync),
        .o_valid(o_valid), .o_col(o_col), .o_row(o_row), .o_idx(o_idx),
        .o_sof(o_sof), .o_eof(o_eof)
    );

    sw_scan_ctrl #(
        .COL_N(8), .ROW_N(4), .WIN_C(3), .WIN_R(2), .STRIDE_C(2), .STRIDE_R(2)
    ) u_small (
        .clk(clk), .rst(rst), .i_valid(s_valid), .i_sync(s_sync),
        .o_valid(so_valid), .o_col(so_col), .o_row(so_row), .o_idx(so_idx),
        .o_sof(so_sof), .o_eof(so_eof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    errors, checks;
    string cur_test;
    obs_t  sb_q[$];
    win_t  win_q[$];

    int m_col, m_row, m_idx;
    logic [5:0]  h_col;
    logic [4:0]  h_row;
    logic [10:0] h_idx;

    int   win_cnt, eof_cnt, cell_no, first_win_cell, idx0_cnt, eof_cell, sof_cell_after;
    obs_t last_win;

    function automatic obs_t cur_obs();
        return {o_valid, o_sof, o_eof, o_col, o_row, o_idx};
    endfunction

    task automatic model_reset();
        m_col = 0; m_row = 0; m_idx = 0;
        h_col = '0; h_row = '0; h_idx = '0;
        sb_q.delete();
    endtask

    task automatic clr_stats();
        win_cnt = 0; eof_cnt = 0; cell_no = 0; first_win_cell = -1;
        idx0_cnt = 0; eof_cell = -1; sof_cell_after = -1; last_win = '0;
    endtask

    task automatic model_step(input bit v, input bit s, output obs_t e);
        e = '0;
        if (s) begin
            m_col = 0; m_row = 0; m_idx = 0;
        end
        if (v) begin
            if (m_col >= WC - 1 && m_row >= WR - 1) begin
                e.v   = 1'b1;
                h_col = 6'(m_col - WC + 1);
                h_row = 5'(m_row - WR + 1);
                h_idx = 11'(m_idx);
                m_idx++;
            end
            e.sof = (m_col == 0 && m_row == 0);
            e.eof = (m_col == CN - 1 && m_row == RN - 1);
            if (e.eof) m_idx = 0;
            m_col++;
            if (m_col == CN) begin
                m_col = 0;
                m_row++;
                if (m_row == RN) m_row = 0;
            end
        end
        e.col = h_col; e.row = h_row; e.idx = h_idx;
    endtask

    // One clock with the given inputs; expected output queued, then popped and compared
    task automatic drive(input bit v, input bit s);
        obs_t e, o;
        int   this_cell;
        model_step(v, s, e);
        sb_q.push_back(e);
        this_cell = cell_no;
        if (v) cell_no++;
        i_valid = v; i_sync = s;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        o = cur_obs();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL %s cell %0d: got v=%0b sof=%0b eof=%0b col=%0d row=%0d idx=%0d, want v=%0b sof=%0b eof=%0b col=%0d row=%0d idx=%0d",
                     cur_test, this_cell, o.v, o.sof, o.eof, o.col, o.row, o.idx,
                     e.v, e.sof, e.eof, e.col, e.row, e.idx);
        end
        if (o_valid) begin
            win_cnt++;
            last_win = o;
            if (first_win_cell < 0) first_win_cell = this_cell;
            if (o_idx == 11'd0) idx0_cnt++;
        end
        if (o_eof) begin
            eof_cnt++;
            eof_cell = this_cell;
        end
        if (o_sof && eof_cell >= 0 && sof_cell_after < 0) sof_cell_after = this_cell;
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic check_last_win(input string name);
        obs_t want;
        want = {1'b1, 1'b0, 1'b1, 6'd32, 5'd14, 11'd494};
        checks++;
        if (last_win !== want) begin
            errors++;
            $display("FAIL %s: last window v=%0b eof=%0b col=%0d row=%0d idx=%0d, want eof=1 col=32 row=14 idx=494",
                     name, last_win.v, last_win.eof, last_win.col, last_win.row, last_win.idx);
        end
    endtask

    task automatic full_frame(input string name);
        clr_stats();
        for (int i = 0; i < FRAME; i++) drive(1'b1, 1'b0);
        check_int({name, "_win_cnt"}, win_cnt, 495);
        check_int({name, "_eof_cnt"}, eof_cnt, 1);
        check_last_win({name, "_last"});
    endtask

    task automatic test_reset();
        cur_test = "reset";
        rst = 1'b1; i_valid = 1'b1; i_sync = 1'b0; s_valid = 1'b1; s_sync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (cur_obs() !== '0) begin
            errors++;
            $display("FAIL reset_main: got %h, want 0", cur_obs());
        end
        checks++;
        if ({so_valid, so_sof, so_eof, so_col, so_row, so_idx} !== '0) begin
            errors++;
            $display("FAIL reset_small: got nonzero outputs, want 0");
        end
        i_valid = 1'b0; s_valid = 1'b0;
        #2 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_full_frame();
        cur_test = "full_frame";
        full_frame("full");
        check_int("full_first_win_cell", first_win_cell, 552);
    endtask

    task automatic test_gapped();
        int cells;
        cur_test = "gapped";
        clr_stats();
        cells = 0;
        while (cells < FRAME) begin
            if ($urandom_range(1) == 1) begin
                drive(1'b1, 1'b0);
                cells++;
            end else begin
                drive(1'b0, 1'b0);
            end
        end
        check_int("gapped_win_cnt", win_cnt, 495);
        check_last_win("gapped_last");
    endtask

    task automatic test_sync();
        cur_test = "sync_valid";
        clr_stats();
        for (int i = 0; i < 300; i++) drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        check_int("sync_sof_pulse", int'(o_sof), 1);
        for (int i = 0; i < FRAME - 1; i++) drive(1'b1, 1'b0);
        check_int("sync_win_cnt", win_cnt, 495);
        check_int("sync_eof_cnt", eof_cnt, 1);
        check_last_win("sync_last");

        cur_test = "sync_idle";
        for (int i = 0; i < 600; i++) drive(1'b1, 1'b0);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        full_frame("sync_idle");
    endtask

    task automatic test_reset_mid();
        cur_test = "reset_mid";
        clr_stats();
        for (int i = 0; i < 700; i++) drive(1'b1, 1'b0);
        i_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (cur_obs() !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: got %h, want 0", cur_obs());
        end
        #1 rst = 1'b0;
        model_reset();
        full_frame("after_reset");
        check_int("after_reset_first_win_cell", first_win_cell, 552);
    endtask

    task automatic test_back_to_back();
        cur_test = "back_to_back";
        clr_stats();
        for (int i = 0; i < 2 * FRAME; i++) drive(1'b1, 1'b0);
        check_int("b2b_win_cnt", win_cnt, 990);
        check_int("b2b_eof_cnt", eof_cnt, 2);
        check_int("b2b_idx0_cnt", idx0_cnt, 2);
        check_int("b2b_sof_after_eof", sof_cell_after, FRAME);
        check_int("b2b_last_eof_cell", eof_cell, 2 * FRAME - 1);
    endtask

    task automatic test_stride();
        int   got, eofs;
        win_t w, o;
        cur_test = "stride";
        win_q.delete();
        win_q.push_back({6'd0, 5'd0, 11'd0});
        win_q.push_back({6'd2, 5'd0, 11'd1});
        win_q.push_back({6'd4, 5'd0, 11'd2});
        win_q.push_back({6'd0, 5'd2, 11'd3});
        win_q.push_back({6'd2, 5'd2, 11'd4});
        win_q.push_back({6'd4, 5'd2, 11'd5});
        got = 0; eofs = 0;
        for (int i = 0; i < 32; i++) begin
            s_valid = 1'b1;
            @(posedge clk);
            #1;
            if (so_eof) eofs++;
            if (so_valid) begin
                got++;
                o = {so_col, so_row, so_idx};
                checks++;
                if (win_q.size() == 0) begin
                    errors++;
                    $display("FAIL stride_extra cell %0d: got col=%0d row=%0d idx=%0d, want no window",
                             i, so_col, so_row, so_idx);
                end else begin
                    w = win_q.pop_front();
                    if (o !== w) begin
                        errors++;
                        $display("FAIL stride_win cell %0d: got col=%0d row=%0d idx=%0d, want col=%0d row=%0d idx=%0d",
                                 i, o.col, o.row, o.idx, w.col, w.row, w.idx);
                    end
                end
            end
        end
        s_valid = 1'b0;
        check_int("stride_win_cnt", got, 6);
        check_int("stride_left_in_queue", win_q.size(), 0);
        check_int("stride_eof_cnt", eofs, 1);
    endtask

    initial begin
        errors = 0; checks = 0;
        rst = 1'b1; i_valid = 1'b0; i_sync = 1'b0; s_valid = 1'b0; s_sync = 1'b0;
        model_reset();
        clr_stats();
        test_reset();
        test_full_frame();
        test_gapped();
        test_sync();
        test_reset_mid();
        test_back_to_back();
        test_stride();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
